// File: rtl/avm_uart_responder_if.sv
// Avalon-MM slave bus bundle for the UART responder register window.
interface avm_uart_responder_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avm_uart_responder.sv
// Avalon-MM responder exposing an RX/TX byte-FIFO pair behind a fixed-latency
// waitrequest handshake. Registers: 0 = RX data, 4 = TX data, 8 = STATUS
// (bit8 TOE sticky TX overrun, bit7 RX non-empty, bit6 TX not full).
// Optional build macro AVM_UART_LOOPBACK_EN routes the TX FIFO head straight
// into the RX FIFO and idles the external byte-stream ports.
module avm_uart_responder #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 avm_clk,
  input  logic                 avm_rst,
  avm_uart_responder_if.slave  avs,
  input  logic [7:0]           rx_byte_data,
  input  logic                 rx_byte_valid,
  output logic                 rx_byte_ready,
  output logic [7:0]           tx_byte_data,
  output logic                 tx_byte_valid,
  input  logic                 tx_byte_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WC_W  = 4;

  localparam logic [4:0]       ADDR_RX  = 5'd0;
  localparam logic [4:0]       ADDR_TX  = 5'd4;
  localparam logic [4:0]       ADDR_ST  = 5'd8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_ACK} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              waitreq_q;
  logic              toe_q;

  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wptr_q, rx_rptr_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wptr_q, tx_rptr_q;
  logic [CNT_W-1:0]  tx_cnt_q;

  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]        rx_push_data, rx_head, tx_head;
  logic              ack, bus_rd, bus_wr, toe_set, toe_clr;
  logic [31:0]       rdata_c;
  logic              wdata_unused;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CNT_FULL);
  assign rx_head  = rx_mem[rx_rptr_q];
  assign tx_head  = tx_mem[tx_rptr_q];

  // Only the low byte of write data carries payload.
  assign wdata_unused = ^avs.avs_writedata[31:8];

  // Bus FSM state, stall counter and registered waitrequest.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      waitreq_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      waitreq_q <= (state_d != ST_ACK);
    end
  end

  // Next state: every request pays one idle cycle, WAIT_CYCLES stalls, then ACK.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (avs.avs_read | avs.avs_write) begin
          state_d = ST_STALL;
          wcnt_d  = '0;
        end
      end
      ST_STALL: begin
        if (wcnt_q == WC_LAST) state_d = ST_ACK;
        else                   wcnt_d  = wcnt_q + WC_W'(1);
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign avs.avs_waitrequest = waitreq_q;

  // Completion-cycle decode; a simultaneous read and write is treated as a read.
  assign ack     = (state_q == ST_ACK);
  assign bus_rd  = ack & avs.avs_read;
  assign bus_wr  = ack & avs.avs_write & ~avs.avs_read;
  assign rx_pop  = bus_rd & (avs.avs_address == ADDR_RX) & ~rx_empty;
  assign tx_push = bus_wr & (avs.avs_address == ADDR_TX) & ~tx_full;
  assign toe_set = bus_wr & (avs.avs_address == ADDR_TX) & tx_full;
  assign toe_clr = bus_wr & (avs.avs_address == ADDR_ST);

  // Read data is driven only in the completion cycle, from start-of-cycle state.
  always_comb begin
    rdata_c = '0;
    if (bus_rd) begin
      case (avs.avs_address)
        ADDR_RX: if (!rx_empty) rdata_c = {24'h0, rx_head};
        ADDR_ST: rdata_c = {23'h0, toe_q, ~rx_empty, ~tx_full, 6'h0};
        default: rdata_c = '0;
      endcase
    end
  end

  assign avs.avs_readdata = rdata_c;

`ifdef AVM_UART_LOOPBACK_EN
  logic stream_unused;
  logic lb_move;
  assign stream_unused = ^{rx_byte_data, rx_byte_valid, tx_byte_ready};
  assign lb_move       = ~tx_empty & ~rx_full;
  assign rx_push       = lb_move;
  assign rx_push_data  = tx_head;
  assign tx_pop        = lb_move;
  assign rx_byte_ready = 1'b0;
  assign tx_byte_valid = 1'b0;
  assign tx_byte_data  = 8'h00;
`else
  assign rx_push       = rx_byte_valid & ~rx_full;
  assign rx_push_data  = rx_byte_data;
  assign tx_pop        = tx_byte_ready & ~tx_empty;
  assign rx_byte_ready = ~rx_full;
  assign tx_byte_valid = ~tx_empty;
  assign tx_byte_data  = tx_empty ? 8'h00 : tx_head;
`endif

  // Sticky TX overrun flag.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst)      toe_q <= 1'b0;
    else if (toe_set) toe_q <= 1'b1;
    else if (toe_clr) toe_q <= 1'b0;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
      rx_cnt_q <= rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_push_data;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
      tx_cnt_q <= tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    end
  end

  // TX FIFO storage.
  always_ff @(posedge avm_clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= avs.avs_writedata[7:0];
  end

endmodule
